// File: rtl/idu_decode_stage.sv
// RV32I decode stage: one-entry holding register between fetch and execute,
// with combinational decode of the held instruction word.
module idu_decode_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h3000_0000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_inst,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_rd_wen,
    output logic [2:0]      out_func3,
    output logic [2:0]      out_fu,
    output logic [3:0]      out_alu_op,
    output logic            out_src_a_pc,
    output logic            out_src_b_imm,
    output logic            out_illegal
);

    typedef enum logic [2:0] {
        FU_ALU    = 3'd0,
        FU_BRANCH = 3'd1,
        FU_JUMP   = 3'd2,
        FU_LOAD   = 3'd3,
        FU_STORE  = 3'd4,
        FU_CSR    = 3'd5,
        FU_SYSTEM = 3'd6,
        FU_NOP    = 3'd7
    } fu_e;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // FENCE encoding decodes to all-zero fields with fu=NOP, matching the reset view.
    localparam logic [31:0] RESET_INST = 32'h0000_000F;

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_inst;

    logic            w_accept;
    logic            w_drain;

    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_drain  = r_valid && out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_pc    <= RESET_PC;
            r_inst  <= RESET_INST;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_pc    <= in_pc;
            r_inst  <= in_inst;
        end else if (w_drain) begin
            r_valid <= 1'b0;
        end
    end

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic [31:0] w_imm_csr;

    assign w_opcode  = r_inst[6:0];
    assign w_f3      = r_inst[14:12];
    assign w_f7      = r_inst[31:25];
    assign w_imm_i   = {{20{r_inst[31]}}, r_inst[31:20]};
    assign w_imm_s   = {{20{r_inst[31]}}, r_inst[31:25], r_inst[11:7]};
    assign w_imm_b   = {{19{r_inst[31]}}, r_inst[31], r_inst[7], r_inst[30:25], r_inst[11:8], 1'b0};
    assign w_imm_u   = {r_inst[31:12], 12'b0};
    assign w_imm_j   = {{11{r_inst[31]}}, r_inst[31], r_inst[19:12], r_inst[20], r_inst[30:21], 1'b0};
    assign w_imm_csr = {20'b0, r_inst[31:20]};

    fu_e         w_fu;
    alu_e        w_alu;
    alu_e        w_alu_f3;
    logic        w_a_pc;
    logic        w_b_imm;
    logic [31:0] w_imm;
    logic        w_wen;
    logic        w_illegal;

    // Shared func3 -> ALU op map; SUB/SRA selection is applied per opcode below.
    always_comb begin
        w_alu_f3 = ALU_ADD;
        case (w_f3)
            3'b000: w_alu_f3 = ALU_ADD;
            3'b001: w_alu_f3 = ALU_SLL;
            3'b010: w_alu_f3 = ALU_SLT;
            3'b011: w_alu_f3 = ALU_SLTU;
            3'b100: w_alu_f3 = ALU_XOR;
            3'b101: w_alu_f3 = (w_f7 == 7'h20) ? ALU_SRA : ALU_SRL;
            3'b110: w_alu_f3 = ALU_OR;
            3'b111: w_alu_f3 = ALU_AND;
            default: w_alu_f3 = ALU_ADD;
        endcase
    end

    always_comb begin
        w_fu      = FU_ALU;
        w_alu     = ALU_ADD;
        w_a_pc    = 1'b0;
        w_b_imm   = 1'b0;
        w_imm     = 32'b0;
        w_wen     = 1'b0;
        w_illegal = 1'b0;
        case (w_opcode)
            OPC_LUI: begin
                w_alu   = ALU_PASSB;
                w_b_imm = 1'b1;
                w_imm   = w_imm_u;
                w_wen   = 1'b1;
            end
            OPC_AUIPC: begin
                w_a_pc  = 1'b1;
                w_b_imm = 1'b1;
                w_imm   = w_imm_u;
                w_wen   = 1'b1;
            end
            OPC_JAL: begin
                w_fu   = FU_JUMP;
                w_a_pc = 1'b1;
                w_imm  = w_imm_j;
                w_wen  = 1'b1;
            end
            OPC_JALR: begin
                w_fu   = FU_JUMP;
                w_a_pc = 1'b1;
                w_imm  = w_imm_i;
                w_wen  = 1'b1;
            end
            OPC_BRANCH: begin
                w_fu      = FU_BRANCH;
                w_imm     = w_imm_b;
                w_illegal = (w_f3 == 3'd2) || (w_f3 == 3'd3);
            end
            OPC_LOAD: begin
                w_fu      = FU_LOAD;
                w_imm     = w_imm_i;
                w_wen     = 1'b1;
                w_illegal = (w_f3 == 3'd3) || (w_f3 == 3'd6) || (w_f3 == 3'd7);
            end
            OPC_STORE: begin
                w_fu      = FU_STORE;
                w_imm     = w_imm_s;
                w_illegal = (w_f3 > 3'd2);
            end
            OPC_OPIMM: begin
                w_alu     = w_alu_f3;
                w_b_imm   = 1'b1;
                w_imm     = w_imm_i;
                w_wen     = 1'b1;
                w_illegal = ((w_f3 == 3'b001) && (w_f7 != 7'h00)) ||
                            ((w_f3 == 3'b101) && (w_f7 != 7'h00) && (w_f7 != 7'h20));
            end
            OPC_OP: begin
                w_alu     = ((w_f3 == 3'b000) && (w_f7 == 7'h20)) ? ALU_SUB : w_alu_f3;
                w_wen     = 1'b1;
                w_illegal = !((w_f7 == 7'h00) ||
                              ((w_f7 == 7'h20) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))));
            end
            OPC_MISC: begin
                w_fu = FU_NOP;
            end
            OPC_SYSTEM: begin
                if (w_f3 == 3'b000) begin
                    w_fu      = FU_SYSTEM;
                    w_illegal = !((r_inst == 32'h0000_0073) ||
                                  (r_inst == 32'h0010_0073) ||
                                  (r_inst == 32'h3020_0073));
                end else if (w_f3 == 3'b100) begin
                    w_illegal = 1'b1;
                end else begin
                    w_fu  = FU_CSR;
                    w_imm = w_imm_csr;
                    w_wen = 1'b1;
                end
            end
            default: w_illegal = 1'b1;
        endcase
        if (w_illegal) begin
            w_fu  = FU_SYSTEM;
            w_wen = 1'b0;
        end
    end

    assign out_valid     = r_valid;
    assign out_pc        = r_pc;
    assign out_imm       = XLEN'($signed(w_imm));
    assign out_rs1       = r_inst[19:15];
    assign out_rs2       = r_inst[24:20];
    assign out_rd        = r_inst[11:7];
    assign out_rd_wen    = w_wen && (r_inst[11:7] != 5'd0);
    assign out_func3     = w_f3;
    assign out_fu        = w_fu;
    assign out_alu_op    = w_alu;
    assign out_src_a_pc  = w_a_pc;
    assign out_src_b_imm = w_b_imm;
    assign out_illegal   = w_illegal;

endmodule

// File: doc/idu_decode_stage.md
Name: idu_decode_stage

Overview:
- RV32I instruction-decode stage directly downstream of the instruction fetch unit.
- Accepts (pc, inst) beats over a valid/ready handshake and captures each accepted beat in a one-entry pipeline register.
- Drives decoded control, register indices and a sign-extended immediate to the execute stage over a second valid/ready handshake.
- Supports pipeline flush from later stages (branch redirect, trap).

Parameters:
- XLEN, 32, datapath and PC width.
- RESET_PC, 32'h3000_0000, reset value of out_pc (debug visibility only).

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  fetch beat valid
- in_ready  out  1  stage can accept a beat
- in_pc  in  XLEN  PC of fetched instruction
- in_inst  in  32  fetched instruction word
- flush  in  1  discard held and incoming beat
- out_valid  out  1  decoded beat valid
- out_ready  in  1  execute stage accepts
- out_pc  out  XLEN  held PC
- out_imm  out  XLEN  sign-extended immediate
- out_rs1  out  5  source reg 1 index
- out_rs2  out  5  source reg 2 index
- out_rd  out  5  destination index
- out_rd_wen  out  1  writes rd (forced 0 when rd==0)
- out_func3  out  3  inst[14:12] passthrough
- out_fu  out  3  0 ALU, 1 BRANCH, 2 JUMP, 3 LOAD, 4 STORE, 5 CSR, 6 SYSTEM, 7 NOP (FENCE)
- out_alu_op  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB
- out_src_a_pc  out  1  ALU A = pc (AUIPC, JAL, JALR link)
- out_src_b_imm  out  1  ALU B = imm
- out_illegal  out  1  unrecognised encoding

Behaviour:
- Reset:
  - out_valid=0, out_pc=RESET_PC.
  - All other registered outputs are 0 and out_fu=7.
  - in_ready=1 from the first cycle after reset deasserts.
- Holding register:
  - in_ready = !out_valid || out_ready (combinational; no dependence on in_valid).
  - On in_valid && in_ready && !flush: capture in_pc and in_inst, set out_valid=1 next cycle. Latency is 1 cycle from acceptance to out_valid.
  - On out_valid && out_ready with no new accept: out_valid=0 next cycle.
  - Accept and drain in the same cycle: the new beat replaces the old one, giving back-to-back throughput of 1 beat/cycle.
  - out_* are stable while out_valid && !out_ready.
- Flush: out_valid=0 next cycle and the incoming beat is dropped, even when in_valid=1. Flush has priority over accept and over drain.
- Decoding:
  - Decode is combinational from the held instruction register.
  - Decode outputs are don't-care while out_valid=0, except that they must not change while a beat is stalled.
- Immediates (sign bit inst[31]):
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - R-type: imm=0.
- Opcode mapping:
  - LUI: ALU/PASSB, b_imm.
  - AUIPC: ALU/ADD, a_pc, b_imm.
  - JAL: JUMP, a_pc.
  - JALR: JUMP, a_pc, I-imm.
  - BRANCH: rd_wen=0. func3 2 and 3 are illegal.
  - LOAD: func3 in {0,1,2,4,5}, otherwise illegal.
  - STORE: func3 in {0,1,2}, rd_wen=0.
  - OP-IMM: b_imm. For shifts, inst[31:25] must be 0 (SRAI: 0x20), otherwise illegal.
  - OP: inst[31:25] must be 0, or 0x20 for SUB/SRA, otherwise illegal.
  - MISC-MEM: NOP.
  - SYSTEM, func3=0: 0x00000073 ECALL, 0x00100073 EBREAK, 0x30200073 MRET map to SYSTEM with rd_wen=0. Any other SYSTEM word with func3=0 is illegal.
  - SYSTEM, func3 in {1,2,3,5,6,7}: CSR, imm = zero-extended csr address inst[31:20].
  - Any other opcode: illegal.
- Illegal beats: out_illegal=1, out_fu=SYSTEM, rd_wen=0. The beat is still handed off normally; the trap is taken downstream.
- Reset mid-transfer: the held beat is discarded and there is no partial output.

Test Plan:
- Accept 0x00500093 at pc 0x30000000 -> next cycle: out_valid=1, fu=0, alu_op=0, rd=1, rs1=0, imm=5, b_imm=1, rd_wen=1.
- 0x12345137 -> fu=0, alu_op=10, rd=2, imm=0x12345000. Then 0xFE000EE3 -> fu=1, imm=0xFFFFFFFC, rd_wen=0.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out_* unchanged. Release -> the next beat appears the following cycle, with no loss and no duplication.
- Stream 4 beats with out_ready=1 -> out_valid high for 4 consecutive cycles, PCs in order.
- Flush while full and in_valid=1 -> out_valid=0 next cycle, and neither the held beat nor the incoming beat ever appears.
- 0xFFFFFFFF -> illegal=1. 0x00100073 -> fu=6, illegal=0. 0x30002573 (csrrs a0, mstatus) -> fu=5, rd=10, imm=0x300.
